// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encoding and bus command record for the IF/MEM memory arbiter.
`default_nettype none

package mem_arbiter_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int BE_WIDTH   = DATA_WIDTH / 8;

   localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IF   = 2'd1,
      ARB_MEM  = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic                  we;
      logic [BE_WIDTH-1:0]   be;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } bus_cmd_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store,
// with a bounded MEM-priority streak and optional byte-lane reversal.
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int FAIR_LIMIT = 4,
   parameter bit SWAP_BYTES = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_done,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [BE_WIDTH-1:0]   mem_be,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_done,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [BE_WIDTH-1:0]   bus_be,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   localparam int STREAK_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(FAIR_LIMIT);

   function automatic logic [DATA_WIDTH-1:0] lane_word(input logic [DATA_WIDTH-1:0] w);
      logic [DATA_WIDTH-1:0] r;
      r = w;
      if (SWAP_BYTES) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            r[8*i +: 8] = w[8*(BE_WIDTH-1-i) +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [BE_WIDTH-1:0] lane_be(input logic [BE_WIDTH-1:0] b);
      logic [BE_WIDTH-1:0] r;
      r = b;
      if (SWAP_BYTES) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            r[i] = b[BE_WIDTH-1-i];
         end
      end
      return r;
   endfunction

   arb_state_e            state_q;
   bus_cmd_t              cmd_q;
   bus_cmd_t              cmd_d;
   logic                  bus_req_q;
   logic                  if_done_q;
   logic                  mem_done_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] mem_rdata_q;
   logic [STREAK_W-1:0]   streak_q;
   logic [STREAK_W-1:0]   streak_d;

   logic if_valid;
   logic mem_valid;
   logic fair_hit;
   logic grant_if;
   logic grant_mem;

   // A requester still holding req in its own done cycle is the finished access, not a new one.
   always_comb begin
      if_valid  = if_req && !if_done_q;
      mem_valid = mem_req && !mem_done_q;
      fair_hit  = (FAIR_LIMIT != 0) && (streak_q >= STREAK_MAX);
      grant_if  = if_valid && (!mem_valid || fair_hit);
      grant_mem = mem_valid && !grant_if;
      streak_d  = (streak_q < STREAK_MAX) ? streak_q + STREAK_W'(1) : streak_q;

      cmd_d = '0;
      if (grant_if) begin
         cmd_d.we    = 1'b0;
         cmd_d.be    = '1;
         cmd_d.addr  = if_addr;
         cmd_d.wdata = ZERO_WORD;
      end else if (grant_mem) begin
         cmd_d.we    = mem_we;
         cmd_d.be    = lane_be(mem_be);
         cmd_d.addr  = mem_addr;
         cmd_d.wdata = lane_word(mem_wdata);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ARB_IDLE;
         cmd_q       <= '0;
         bus_req_q   <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_rdata_q  <= ZERO_WORD;
         mem_rdata_q <= ZERO_WORD;
         streak_q    <= '0;
      end else begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (grant_if) begin
                  cmd_q     <= cmd_d;
                  bus_req_q <= 1'b1;
                  streak_q  <= '0;
                  state_q   <= ARB_IF;
               end else if (grant_mem) begin
                  cmd_q     <= cmd_d;
                  bus_req_q <= 1'b1;
                  streak_q  <= streak_d;
                  state_q   <= ARB_MEM;
               end
            end
            ARB_IF: begin
               if (bus_ack) begin
                  if_rdata_q <= lane_word(bus_rdata);
                  if_done_q  <= 1'b1;
                  bus_req_q  <= 1'b0;
                  state_q    <= ARB_IDLE;
               end
            end
            ARB_MEM: begin
               if (bus_ack) begin
                  if (!cmd_q.we) begin
                     mem_rdata_q <= lane_word(bus_rdata);
                  end
                  mem_done_q <= 1'b1;
                  bus_req_q  <= 1'b0;
                  state_q    <= ARB_IDLE;
               end
            end
            default: begin
               bus_req_q <= 1'b0;
               state_q   <= ARB_IDLE;
            end
         endcase
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_done   = if_done_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_done  = mem_done_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = cmd_q.we;
   assign bus_be    = cmd_q.be;
   assign bus_addr  = cmd_q.addr;
   assign bus_wdata = cmd_q.wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single accesses plus reset, fairness and stale-request sequences.
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

   logic        CLK;
   logic        RST;
   logic        if_req;
   logic [31:0] if_addr;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
   logic        if_done, mem_done, bus_req, bus_we;
   logic [3:0]  bus_be;

   logic [31:0] b_if_rdata, b_mem_rdata, b_bus_addr, b_bus_wdata;
   logic        b_if_done, b_mem_done, b_bus_req, b_bus_we;
   logic [3:0]  b_bus_be;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.FAIR_LIMIT(4), .SWAP_BYTES(1'b1)) u_dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   mem_arbiter #(.FAIR_LIMIT(0), .SWAP_BYTES(1'b1)) u_dut_strict (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_done(b_if_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(b_mem_rdata), .mem_done(b_mem_done),
      .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_be(b_bus_be), .bus_addr(b_bus_addr),
      .bus_wdata(b_bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_if;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_bus_req(input string name);
      int n;
      n = 0;
      while (bus_req !== 1'b1 && n < 30) begin
         @(negedge CLK);
         n++;
      end
      chk({name, " bus_req wait"}, {31'd0, bus_req}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; if_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      @(negedge CLK);
      if_req = v.is_if; mem_req = !v.is_if;
      mem_we = v.we; mem_be = v.be; mem_wdata = v.wdata;
      if_addr = v.addr; mem_addr = v.addr;
      @(negedge CLK);
      chk({p, " bus_req"}, {31'd0, bus_req}, 32'd1);
      chk({p, " bus_we"}, {31'd0, bus_we}, {31'd0, v.exp_we});
      chk({p, " bus_be"}, {28'd0, bus_be}, {28'd0, v.exp_be});
      chk({p, " bus_addr"}, bus_addr, v.addr);
      chk({p, " bus_wdata"}, bus_wdata, v.exp_wdata);
      mem_wdata = ~v.wdata; mem_addr = v.addr ^ 32'hFF0; if_addr = v.addr ^ 32'hFF0;
      for (int k = 1; k < v.lat; k++) begin
         chk({p, " early done"}, {30'd0, if_done, mem_done}, 32'd0);
         @(negedge CLK);
         chk({p, " bus_req held"}, {31'd0, bus_req}, 32'd1);
      end
      bus_ack = 1'b1; bus_rdata = v.rdata;
      @(negedge CLK);
      bus_ack = 1'b0; bus_rdata = 32'h0;
      chk({p, " dones"}, {30'd0, if_done, mem_done}, v.is_if ? 32'd2 : 32'd1);
      chk({p, " bus_req off"}, {31'd0, bus_req}, 32'd0);
      chk({p, " bus_addr kept"}, bus_addr, v.addr);
      chk({p, " bus_wdata kept"}, bus_wdata, v.exp_wdata);
      if (v.is_if) chk({p, " if_rdata"}, if_rdata, v.exp_rdata);
      else         chk({p, " mem_rdata"}, mem_rdata, v.exp_rdata);
      if_req = 1'b0; mem_req = 1'b0;
      @(negedge CLK);
      chk({p, " done pulse end"}, {30'd0, if_done, mem_done}, 32'd0);
      if (v.is_if) chk({p, " if_rdata held"}, if_rdata, v.exp_rdata);
      else         chk({p, " mem_rdata held"}, mem_rdata, v.exp_rdata);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 4'b0101, 32'h100, 32'h0,        32'h13000000, 1, 1'b0, 4'hF,    32'h0,        32'h00000013};
      vecs[1] = '{1'b0, 1'b0, 4'b1111, 32'h200, 32'h0,        32'h11223344, 2, 1'b0, 4'hF,    32'h0,        32'h44332211};
      vecs[2] = '{1'b0, 1'b1, 4'b0001, 32'h204, 32'hAABBCCDD, 32'hDEADBEEF, 1, 1'b1, 4'b1000, 32'hDDCCBBAA, 32'h44332211};
      vecs[3] = '{1'b0, 1'b1, 4'b0110, 32'h208, 32'h01234567, 32'h0,        3, 1'b1, 4'b0110, 32'h67452301, 32'h44332211};
      vecs[4] = '{1'b0, 1'b1, 4'b0011, 32'h20C, 32'h0000FFEE, 32'h0,        1, 1'b1, 4'b1100, 32'hEEFF0000, 32'h44332211};
      vecs[5] = '{1'b1, 1'b0, 4'b0000, 32'h104, 32'h0,        32'h6F000000, 4, 1'b0, 4'hF,    32'h0,        32'h0000006F};
      vecs[6] = '{1'b0, 1'b0, 4'b0100, 32'h210, 32'h0,        32'hA1B2C3D4, 1, 1'b0, 4'b0010, 32'h0,        32'hD4C3B2A1};

      RST = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_be = 4'h0;
      if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

      @(negedge CLK);
      chk("reset ctrl", {26'd0, bus_req, bus_we, bus_be}, 32'd0);
      chk("reset bus_addr", bus_addr, 32'h0);
      chk("reset bus_wdata", bus_wdata, 32'h0);
      chk("reset rdata", if_rdata | mem_rdata, 32'h0);
      chk("reset dones", {30'd0, if_done, mem_done}, 32'd0);
      chk("reset strict", b_if_rdata | b_mem_rdata | b_bus_addr | b_bus_wdata |
          {26'd0, b_bus_req, b_bus_we, b_bus_be} | {30'd0, b_if_done, b_mem_done}, 32'h0);
      RST = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Reset asserted while a store is on the bus
      @(negedge CLK);
      mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hF; mem_addr = 32'h300; mem_wdata = 32'h55;
      @(negedge CLK);
      chk("rst pre bus_req", {31'd0, bus_req}, 32'd1);
      #2 RST = 1'b1;
      #1;
      chk("rst async bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst async bus_addr", bus_addr, 32'h0);
      chk("rst async mem_rdata", mem_rdata, 32'h0);
      chk("rst async if_rdata", if_rdata, 32'h0);
      chk("rst async ctrl", {27'd0, bus_we, bus_be}, 32'd0);
      @(negedge CLK);
      RST = 1'b0; mem_req = 1'b0; bus_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk($sformatf("rst no done %0d", k), {29'd0, bus_req, if_done, mem_done}, 32'd0);
      end
      bus_ack = 1'b0;

      // Fairness: four MEM accesses build the streak, then a fresh IF beats MEM (strict instance keeps MEM)
      do_reset();
      @(negedge CLK);
      mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h400; if_addr = 32'h500; if_req = 1'b0;
      for (int g = 0; g < 4; g++) begin
         wait_bus_req($sformatf("fair%0d", g));
         chk($sformatf("fair%0d addr", g), bus_addr, 32'h400);
         chk($sformatf("fair%0d strict addr", g), b_bus_addr, 32'h400);
         @(negedge CLK);
         @(negedge CLK);
         bus_ack = 1'b1; bus_rdata = 32'h0;
         @(negedge CLK);
         bus_ack = 1'b0;
         chk($sformatf("fair%0d mem_done", g), {31'd0, mem_done}, 32'd1);
         @(negedge CLK);
         chk($sformatf("fair%0d no stale grant", g), {31'd0, bus_req}, 32'd0);
      end
      if_req = 1'b1;
      @(negedge CLK);
      chk("fair IF wins addr", bus_addr, 32'h500);
      chk("fair IF wins we", {31'd0, bus_we}, 32'd0);
      chk("strict MEM wins addr", b_bus_addr, 32'h400);
      bus_ack = 1'b1; bus_rdata = 32'h78563412;
      @(negedge CLK);
      bus_ack = 1'b0;
      chk("fair if_done", {31'd0, if_done}, 32'd1);
      chk("fair if_rdata", if_rdata, 32'h12345678);
      chk("strict mem_done", {30'd0, b_if_done, b_mem_done}, 32'd1);
      @(negedge CLK);
      chk("fair MEM after IF", bus_addr, 32'h400);
      chk("fair MEM after IF req", {31'd0, bus_req}, 32'd1);
      do_reset();

      // Spurious ack while idle
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         chk($sformatf("spurious ack %0d", k), {29'd0, bus_req, if_done, mem_done}, 32'd0);
      end
      bus_ack = 1'b0;
      chk("spurious ack rdata", if_rdata | mem_rdata, 32'h0);

      // MEM drops its request mid-access; IF held through its done cycle is not regranted there
      @(negedge CLK);
      mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h600; if_req = 1'b1; if_addr = 32'h700;
      @(negedge CLK);
      chk("drop MEM granted", bus_addr, 32'h600);
      mem_req = 1'b0;
      @(negedge CLK);
      bus_ack = 1'b1; bus_rdata = 32'h01020304;
      @(negedge CLK);
      bus_ack = 1'b0;
      chk("drop mem_done", {31'd0, mem_done}, 32'd1);
      chk("drop mem_rdata", mem_rdata, 32'h04030201);
      @(negedge CLK);
      chk("IF after drop", bus_addr, 32'h700);
      chk("IF after drop req", {31'd0, bus_req}, 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'hEF00BEAD;
      @(negedge CLK);
      bus_ack = 1'b0;
      chk("stale if_done", {31'd0, if_done}, 32'd1);
      chk("stale if_rdata", if_rdata, 32'hADBE00EF);
      @(negedge CLK);
      chk("stale not regranted", {31'd0, bus_req}, 32'd0);
      @(negedge CLK);
      chk("stale regranted next", {31'd0, bus_req}, 32'd1);
      chk("stale regranted addr", bus_addr, 32'h700);
      if_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0;
      @(negedge CLK);
      bus_ack = 1'b0;
      chk("final if_done", {31'd0, if_done}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
